// File: rtl/alu_response_checker.sv
// Response checker for the 2-bit ALU test interface: golden model, latency-aligned compare,
// saturating error count and first-failure capture.
module alu_response_checker #(
  parameter  int unsigned LATENCY     = 0,
  parameter  int unsigned NUM_VECTORS = 16,
  parameter  int unsigned ERR_CNT_W   = 8,
  localparam int unsigned CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [1:0]           vec_a,
  input  logic [1:0]           vec_b,
  input  logic [1:0]           vec_sel,
  input  logic [3:0]           alu_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [CNT_W-1:0]     vec_count,
  output logic [1:0]           fail_a,
  output logic [1:0]           fail_b,
  output logic [1:0]           fail_sel,
  output logic [3:0]           fail_y,
  output logic [3:0]           fail_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
    logic [3:0] exp;
  } entry_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);

  state_t               state_q, state_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0]     vc_q, vc_d;
  logic                 pass_q, pass_d;
  logic                 mm_q, mm_d;
  logic [1:0]           fa_q, fa_d, fb_q, fb_d, fs_q, fs_d;
  logic [3:0]           fy_q, fy_d, fe_q, fe_d;

  logic   flush;
  logic   compare;
  logic   miss;
  entry_t in_e;
  entry_t cmp_e;

  assign flush = start || (state_q != RUN);

  always_comb begin
    in_e       = '0;
    in_e.valid = vec_valid && !flush;
    in_e.a     = vec_a;
    in_e.b     = vec_b;
    in_e.sel   = vec_sel;
    unique case (vec_sel)
      2'b00:   in_e.exp = {2'b00, vec_a} + {2'b00, vec_b};
      2'b01:   in_e.exp = {2'b00, vec_a} * {2'b00, vec_b};
      2'b10:   in_e.exp = {2'b00, vec_a & vec_b};
      default: in_e.exp = {2'b00, vec_a | vec_b};
    endcase
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign cmp_e = in_e;
    end else begin : g_pipe
      entry_t pipe_q [LATENCY];
      entry_t pipe_d [LATENCY];

      // Leaving RUN (or restarting) drops every in-flight entry so stale vectors never compare.
      always_comb begin
        pipe_d[0] = in_e;
        for (int unsigned i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        if (flush) begin
          for (int unsigned i = 0; i < LATENCY; i++) pipe_d[i].valid = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign cmp_e = pipe_q[LATENCY-1];
    end
  endgenerate

  assign compare = (state_q == RUN) && !start && cmp_e.valid;
  assign miss    = compare && (alu_y != cmp_e.exp);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    vc_d    = vc_q;
    pass_d  = pass_q;
    mm_d    = 1'b0;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fs_d    = fs_q;
    fy_d    = fy_q;
    fe_d    = fe_q;
    if (start) begin
      state_d = RUN;
      err_d   = '0;
      vc_d    = '0;
      pass_d  = 1'b0;
      fa_d    = '0;
      fb_d    = '0;
      fs_d    = '0;
      fy_d    = '0;
      fe_d    = '0;
    end else if (compare) begin
      vc_d = vc_q + CNT_W'(1);
      if (miss) begin
        mm_d = 1'b1;
        if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
        if (err_q == '0) begin
          fa_d = cmp_e.a;
          fb_d = cmp_e.b;
          fs_d = cmp_e.sel;
          fy_d = alu_y;
          fe_d = cmp_e.exp;
        end
      end
      if (vc_d == LAST_CNT) begin
        state_d = DONE;
        pass_d  = (err_d == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= '0;
      vc_q    <= '0;
      pass_q  <= 1'b0;
      mm_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fs_q    <= '0;
      fy_q    <= '0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vc_q    <= vc_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fs_q    <= fs_d;
      fy_q    <= fy_d;
      fe_q    <= fe_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign mismatch  = mm_q;
  assign err_count = err_q;
  assign vec_count = vc_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_sel  = fs_q;
  assign fail_y    = fy_q;
  assign fail_exp  = fe_q;

endmodule
